// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder/subtractor. Each clock adds CHUNK bits of the operands, and the carry
// is held in a register between chunks. Valid/ready handshakes sit on the input and the output.
module chunked_serial_adder #(
  parameter int WIDTH = 6,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d, sum_q, sum_d;
  logic             sub_q, sub_d, sat_q, sat_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CHUNK:0]   chunk_add;
  logic             msb_cin;

  // The operands shift right by one chunk on every RUN edge. This keeps the active chunk
  // in the low bits, and the result fills in from the top.
  assign chunk_add = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + (CHUNK+1)'(carry_q);
  // On the last chunk, bit CHUNK-1 is the MSB, so sum ^ a ^ b recovers the carry into it.
  assign msb_cin   = chunk_add[CHUNK-1] ^ a_q[CHUNK-1] ^ b_q[CHUNK-1];

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    sub_d   = sub_q;
    sat_d   = sat_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          sub_d   = sub;
          sat_d   = sat;
          carry_d = sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        res_d   = (res_q >> CHUNK) | (WIDTH'(chunk_add[CHUNK-1:0]) << (WIDTH - CHUNK));
        carry_d = chunk_add[CHUNK];
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          cout_d  = chunk_add[CHUNK];
          ovf_d   = msb_cin ^ chunk_add[CHUNK];
          sum_d   = res_d;
          if (sat_q && !sub_q && chunk_add[CHUNK])
            sum_d = '1;
          else if (sat_q && sub_q && !chunk_add[CHUNK])
            sum_d = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the datapath registers are reset together with the FSM. The visible result flags
  // must read 0 after reset, and the whole state is only a few flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      sub_q   <= 1'b0;
      sat_q   <= 1'b0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments make all registers update together from the values before the edge.
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      sub_q   <= sub_d;
      sat_q   <= sat_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule
